// File: rtl/butterfly_pkg.sv
// Shared types and fixed widths for the butterfly result path.
package butterfly_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int LANE_W     = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } collector_state_t;
endpackage

// File: rtl/fft_result_collector_if.sv
// Upstream real/imag streams and downstream complex-vector stream of the collector.
interface fft_result_collector_if #(
    parameter int BE_PARALLELISM  = 32,
    parameter int OUTPUT_AXI_CHNL = 8
);
    localparam int HALF_W = butterfly_pkg::DATA_WIDTH * BE_PARALLELISM;

    logic [OUTPUT_AXI_CHNL-1:0] up_vld_a;
    logic [HALF_W-1:0]          up_dat_a;
    logic                       up_rdy_a;
    logic [OUTPUT_AXI_CHNL-1:0] up_vld_b;
    logic [HALF_W-1:0]          up_dat_b;
    logic                       up_rdy_b;
    logic                       dn_vld;
    logic [2*HALF_W-1:0]        dn_dat;
    logic                       dn_last;
    logic                       dn_rdy;

    modport master (
        output up_vld_a, up_dat_a, up_vld_b, up_dat_b, dn_rdy,
        input  up_rdy_a, up_rdy_b, dn_vld, dn_dat, dn_last
    );

    modport slave (
        input  up_vld_a, up_dat_a, up_vld_b, up_dat_b, dn_rdy,
        output up_rdy_a, up_rdy_b, dn_vld, dn_dat, dn_last
    );
endinterface

// File: rtl/fft_collect_fifo.sv
// First-word-fall-through sync FIFO; head entry is read straight from the storage registers.
module fft_collect_fifo #(
    parameter int WIDTH = 1025,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic                        do_push, do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Masked while empty so a drained FIFO presents zeros, not stale data.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fft_result_collector.sv
// Joins the real (A) and imaginary (B) result streams beat-by-beat into {imag,real} lanes,
// buffers them and frames the output with a beat counter.
module fft_result_collector
    import butterfly_pkg::*;
#(
    parameter int BE_PARALLELISM  = 32,
    parameter int OUTPUT_AXI_CHNL = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  length,
    fft_result_collector_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err_misalign
);
    localparam int BEAT_W = LANE_W * BE_PARALLELISM;

    collector_state_t            state, state_nxt;
    logic [LEN_WIDTH-1:0]        len_q, cnt;
    logic                        zero_len_q;
    logic                        fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [BEAT_W-1:0]           packed_beat;
    logic [BEAT_W:0]             head;
    logic                        vld_a, vld_b, part_a, part_b;
    logic                        rdy, push, pop, last_beat;

    // A side counts only when every channel agrees; a partial mask is a misalignment.
    assign vld_a     = &bus.up_vld_a;
    assign vld_b     = &bus.up_vld_b;
    assign part_a    = (|bus.up_vld_a) && !vld_a;
    assign part_b    = (|bus.up_vld_b) && !vld_b;
    assign rdy       = (state == RUN) && !fifo_full;
    assign push      = vld_a && vld_b && rdy;
    assign pop       = bus.dn_vld && bus.dn_rdy;
    assign last_beat = (cnt == len_q - LEN_WIDTH'(1));

    assign bus.up_rdy_a = rdy;
    assign bus.up_rdy_b = rdy;

    for (genvar g = 0; g < BE_PARALLELISM; g++) begin : g_lane
        assign packed_beat[g*LANE_W +: LANE_W] = {bus.up_dat_b[g*DATA_WIDTH +: DATA_WIDTH],
                                                  bus.up_dat_a[g*DATA_WIDTH +: DATA_WIDTH]};
    end

    fft_collect_fifo #(
        .WIDTH (BEAT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({last_beat, packed_beat}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.dn_vld  = !fifo_empty;
    assign bus.dn_last = head[BEAT_W];
    assign bus.dn_dat  = head[BEAT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start && length != '0) state_nxt = RUN;
            RUN:     if (push && last_beat)     state_nxt = DRAIN;
            DRAIN:   if (fifo_count == '0)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = zero_len_q || ((state == DRAIN) && (fifo_count == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= '0;
            cnt          <= '0;
            zero_len_q   <= 1'b0;
            err_misalign <= 1'b0;
        end else begin
            zero_len_q <= (state == IDLE) && start && (length == '0);
            if ((state == IDLE) && start) begin
                len_q <= length;
                cnt   <= '0;
            end else if (push) begin
                cnt <= cnt + LEN_WIDTH'(1);
            end
            if (part_a || part_b) err_misalign <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_result_collector.sv
// Randomized bench for fft_result_collector against a beat-index reference model.
module tb_fft_result_collector;
    localparam int BE     = 32;
    localparam int CH     = 8;
    localparam int DEPTH  = 8;
    localparam int LW     = 16;
    localparam int HW     = 16 * BE;
    localparam int BW     = 2 * HW;
    localparam int MAXLEN = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] length = '0;
    logic          busy, done, err_misalign;

    fft_result_collector_if #(.BE_PARALLELISM(BE), .OUTPUT_AXI_CHNL(CH)) bus ();

    fft_result_collector #(
        .BE_PARALLELISM (BE),
        .OUTPUT_AXI_CHNL(CH),
        .FIFO_DEPTH     (DEPTH),
        .LEN_WIDTH      (LW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .length       (length),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .err_misalign (err_misalign)
    );

    always #5 clk = ~clk;

    logic [HW-1:0]   dat_a [MAXLEN];
    logic [HW-1:0]   dat_b [MAXLEN];
    logic [BW+1:0]   held;
    int checks = 0, errors = 0;
    int n_push = 0, n_pop = 0, n_done = 0, cur_len = 0;
    int rdy_mode = 0, cyc = 0;
    bit started = 0, abort = 0, hold_pend = 0, exp_rdy;

    task automatic chk(input string tag, input logic [BW+1:0] got, input logic [BW+1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [HW-1:0] rnd_half();
        logic [HW-1:0] r;
        for (int w = 0; w < HW / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Output lane g = {imag_g, real_g} taken from the k-th beat offered on each port.
    function automatic logic [BW-1:0] exp_beat(input int k);
        logic [BW-1:0] r;
        for (int g = 0; g < BE; g++) begin
            r[g*32 +: 16]      = dat_a[k][g*16 +: 16];
            r[g*32 + 16 +: 16] = dat_b[k][g*16 +: 16];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc++;
        #1;
        case (rdy_mode)
            0:       bus.dn_rdy = 1'b1;
            1:       bus.dn_rdy = (cyc % 4 == 0);
            default: bus.dn_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Model: occupancy = accepted - popped; ready while the frame still needs beats and room remains.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_push = 0; n_pop = 0; n_done = 0; hold_pend = 0;
        end else begin
            if (start && !started) begin
                n_push = 0; n_pop = 0; n_done = 0;
            end
            exp_rdy = started && (n_push < cur_len) && (n_push - n_pop < DEPTH);
            chk("up_rdy_a", bus.up_rdy_a, exp_rdy);
            chk("up_rdy_b", bus.up_rdy_b, exp_rdy);
            chk("dn_vld", bus.dn_vld, (n_push - n_pop) > 0);
            if (hold_pend) chk("hold_stable", {bus.dn_vld, bus.dn_last, bus.dn_dat}, held);
            hold_pend = 0;
            if (bus.dn_vld) begin
                if (bus.dn_rdy) begin
                    chk("beat_in_frame", n_pop < cur_len, 1'b1);
                    if (n_pop < cur_len) begin
                        chk("dn_dat", bus.dn_dat, exp_beat(n_pop));
                        chk("dn_last", bus.dn_last, n_pop == cur_len - 1);
                    end
                    n_pop++;
                end else begin
                    hold_pend = 1;
                    held = {bus.dn_vld, bus.dn_last, bus.dn_dat};
                end
            end
            if ((&bus.up_vld_a) && (&bus.up_vld_b) && bus.up_rdy_a) n_push++;
            if (done) begin
                n_done++;
                chk("done_after_drain", n_pop, cur_len);
            end
        end
    end

    // mode 0: always valid; 1: B lags A by 3 cycles; 2: random valids; 3: misaligned A mask first.
    task automatic drive_beats(input int len, input int mode, input bit inject);
        int  i = 0, age = 0, guard = 0;
        bit  va, vb;
        while (i < len && !abort && guard < 20000) begin
            case (mode)
                0:       begin va = 1; vb = 1; end
                1:       begin va = 1; vb = (age >= 3); end
                2:       begin va = ($urandom_range(0, 3) != 0); vb = ($urandom_range(0, 3) != 0); end
                default: begin va = (i > 0 || age >= 4); vb = 1; end
            endcase
            bus.up_vld_a = va ? {CH{1'b1}} : ((mode == 3) ? CH'(8'h0F) : '0);
            bus.up_vld_b = vb ? {CH{1'b1}} : '0;
            bus.up_dat_a = va ? dat_a[i] : rnd_half();
            bus.up_dat_b = vb ? dat_b[i] : rnd_half();
            if (inject && i == 5 && age == 0) begin
                start = 1; length = 3;
            end
            @(posedge clk); #1;
            start = 0;
            guard++; age++;
            if (n_push > i) begin i++; age = 0; end
        end
        if (!abort) chk("producer_progress", guard < 20000, 1'b1);
        bus.up_vld_a = '0;
        bus.up_vld_b = '0;
    endtask

    task automatic begin_frame(input int len, input int rmode);
        for (int k = 0; k < len; k++) begin
            dat_a[k] = rnd_half();
            dat_b[k] = rnd_half();
        end
        rdy_mode = rmode;
        cur_len  = len;
        @(posedge clk); #1;
        start = 1; length = LW'(len);
        @(posedge clk); #1;
        start = 0; started = 1;
    endtask

    task automatic run_frame(input int len, input int mode, input int rmode, input bit inject);
        begin_frame(len, rmode);
        drive_beats(len, mode, inject);
        for (int k = 0; k < 4000 && n_done == 0; k++) @(posedge clk);
        chk("frame_done", n_done, 1);
        @(posedge clk); @(posedge clk); #1;
        chk("frame_beats", n_pop, len);
        chk("done_one_cycle", n_done, 1);
        chk("idle_after_frame", busy, 1'b0);
        started = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.up_vld_a = '0; bus.up_vld_b = '0;
        bus.up_dat_a = '0; bus.up_dat_b = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_dn_vld", bus.dn_vld, 1'b0);
        chk("rst_dn_dat", bus.dn_dat, '0);
        chk("rst_dn_last", bus.dn_last, 1'b0);
        chk("rst_up_rdy", {bus.up_rdy_a, bus.up_rdy_b}, 2'b00);
        chk("rst_busy_done_err", {busy, done, err_misalign}, 3'b000);
        rst_n = 1;

        run_frame(256, 0, 0, 0);
        run_frame(64, 0, 1, 0);
        run_frame(16, 1, 0, 0);
        run_frame(40, 2, 2, 1);

        // Zero length: done on the following cycle, no output beats.
        cur_len = 0;
        @(posedge clk); #1;
        start = 1; length = '0;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        chk("zero_len_done", done, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("zero_len_quiet", {done, busy, bus.dn_vld}, 3'b000);
        end

        chk("err_clean", err_misalign, 1'b0);
        run_frame(8, 3, 0, 0);
        chk("err_set", err_misalign, 1'b1);
        run_frame(12, 0, 2, 0);
        chk("err_sticky", err_misalign, 1'b1);

        // Reset in the middle of a 256-beat frame.
        begin_frame(256, 0);
        fork
            drive_beats(256, 0, 0);
            begin
                for (int k = 0; k < 1000 && n_pop < 100; k++) @(posedge clk);
                chk("mid_reached_100", n_pop >= 100, 1'b1);
                #3;
                abort = 1;
                rst_n = 0;
                #1;
                chk("mid_rst_dn_vld", bus.dn_vld, 1'b0);
                chk("mid_rst_dn_dat", bus.dn_dat, '0);
                chk("mid_rst_dn_last", bus.dn_last, 1'b0);
                chk("mid_rst_up_rdy", {bus.up_rdy_a, bus.up_rdy_b}, 2'b00);
                chk("mid_rst_status", {busy, done, err_misalign}, 3'b000);
            end
        join
        started = 0;
        repeat (2) @(posedge clk); #1;
        abort = 0;
        rst_n = 1;
        run_frame(16, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
